// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART transmitter state encoding and frame constants
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_START,
    ST_DATA,
    ST_STOP
  } uart_state_e;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_STOP_BITS = 1;

  // Index width for a counter over n items, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - bit-period counter producing a one-cycle tick on the last cycle of each bit
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;

  // clear only affects the next count, so tick never depends on it combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear || (cnt_q == CNT_LAST)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - pops FIFO words and sends them as back-to-back 8N1 frames, LSB byte first
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty_i,
  output logic                  fifo_rd_en_o,
  input  logic                  fifo_rd_data_vaild_i,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
  output logic                  tx_o,
  output logic                  busy_o
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam int BYTE_W    = idx_width(NUM_BYTES);
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NUM_BYTES - 1);
  localparam logic [2:0]        LAST_BIT  = 3'(UART_DATA_BITS - 1);

  uart_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [2:0]            bit_q, bit_d;
  logic [BYTE_W-1:0]     byte_q, byte_d;
  logic                  tx_q, tx_d;
  logic                  pop;
  logic                  tick;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clear(state_d != state_q),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    pop     = 1'b0;
    tx_d    = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_i) begin
          pop     = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (fifo_rd_data_vaild_i) begin
          shift_d = fifo_rd_data_i;
          byte_d  = '0;
          bit_d   = '0;
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (tick) begin
          bit_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        // Shifting on every data bit leaves the next byte's LSB at bit 0.
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_q == LAST_BIT) begin
            bit_d   = '0;
            state_d = ST_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (byte_q < LAST_BYTE) begin
            byte_d  = byte_q + BYTE_W'(1);
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Line level is registered from the next state so tx_o tracks state_q exactly.
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  assign fifo_rd_en_o = pop & ~rst;
  assign tx_o         = tx_q;
  assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - directed bench for fifo_uart_tx with a registered-read FIFO model upstream
module tb_fifo_uart_tx;

  localparam int DW  = 32;
  localparam int CPB = 4;

  logic          clk        = 1'b0;
  logic          rst        = 1'b1;
  logic          fifo_empty = 1'b1;
  logic          fifo_valid = 1'b0;
  logic [DW-1:0] fifo_data  = '0;
  logic          fifo_rd_en;
  logic          tx;
  logic          busy;
  logic          push_en    = 1'b0;
  logic [DW-1:0] push_data  = '0;

  int kill_req = 0;
  int kill_seen = 0;
  int cyc = 0;
  int errors = 0;
  int checks = 0;

  logic [DW-1:0] fq[$];
  logic [7:0]    rx_bytes [0:255];
  int            starts   [0:255];
  int            rx_n = 0;
  int            st_n = 0;
  int            pops = 0;
  int            last_pop_cyc = 0;
  int            prev_pop_cyc = 0;
  int            last_busy_cyc = 0;
  int            pop_empty_viol = 0;
  int            pop_busy_viol = 0;
  int            frame_err = 0;
  logic          mon_busy = 1'b0;
  int            mon_t0 = 0;
  logic [7:0]    mon_byte = '0;
  int            rel;

  always #5 clk = ~clk;

  fifo_uart_tx #(
    .DATA_WIDTH  (DW),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .fifo_empty_i        (fifo_empty),
    .fifo_rd_en_o        (fifo_rd_en),
    .fifo_rd_data_vaild_i(fifo_valid),
    .fifo_rd_data_i      (fifo_data),
    .tx_o                (tx),
    .busy_o              (busy)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Depth-8 FIFO with registered read data; an armed kill drops the valid of the next pop.
  always @(posedge clk) begin
    if (rst) begin
      fifo_valid <= 1'b0;
    end else begin
      fifo_valid <= 1'b0;
      if (fifo_rd_en && fq.size() > 0) begin
        fifo_data <= fq.pop_front();
        if (kill_req != kill_seen) kill_seen <= kill_req;
        else fifo_valid <= 1'b1;
      end
      if (push_en && fq.size() < 8) fq.push_back(push_data);
      fifo_empty <= (fq.size() == 0);
    end
  end

  always_comb rel = cyc - mon_t0;

  // UART receiver sampling mid-bit on the falling clock edge.
  always @(negedge clk) begin
    if (rst) begin
      mon_busy <= 1'b0;
    end else if (!mon_busy) begin
      if (tx == 1'b0) begin
        mon_busy     <= 1'b1;
        mon_t0       <= cyc;
        starts[st_n] <= cyc;
        st_n         <= st_n + 1;
      end
    end else begin
      if ((rel % CPB) == CPB / 2 && rel / CPB >= 1 && rel / CPB <= 8)
        mon_byte[rel / CPB - 1] <= tx;
      if (rel == 9 * CPB + CPB / 2) begin
        if (tx !== 1'b1) frame_err <= frame_err + 1;
        rx_bytes[rx_n] <= mon_byte;
        rx_n           <= rx_n + 1;
      end
      if (rel == 10 * CPB - 1) mon_busy <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (busy) last_busy_cyc <= cyc;
    if (fifo_rd_en) begin
      pops         <= pops + 1;
      prev_pop_cyc <= last_pop_cyc;
      last_pop_cyc <= cyc;
      if (fifo_empty) pop_empty_viol <= pop_empty_viol + 1;
      if (busy) pop_busy_viol <= pop_busy_viol + 1;
    end
  end

  task automatic push_word(input logic [DW-1:0] w);
    @(negedge clk);
    push_en   = 1'b1;
    push_data = w;
  endtask

  task automatic end_push();
    @(negedge clk);
    push_en = 1'b0;
  endtask

  task automatic wait_quiet(input int budget, output bit ok);
    int quiet = 0;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy && fifo_empty && !mon_busy && !fifo_rd_en) quiet++;
      else quiet = 0;
      if (quiet >= 3) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int lows = 0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b expected 0", fifo_rd_en); end
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) lows++;
    end
    checks++; if (pops !== 0) begin errors++; $display("FAIL idle_pops: got %0d expected 0", pops); end
    checks++; if (lows !== 0) begin errors++; $display("FAIL idle_line: got %0d active cycles expected 0", lows); end
  endtask

  task automatic test_single_word();
    logic [7:0] exp [4];
    int rb, sb, pb, fe;
    bit ok;
    exp = '{8'h11, 8'h22, 8'h33, 8'h44};
    rb = rx_n; sb = st_n; pb = pops; fe = frame_err;
    push_word(32'h44332211);
    end_push();
    wait_quiet(600, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_done: got busy expected idle within 600 cycles"); end
    checks++; if (pops - pb !== 1) begin errors++; $display("FAIL single_pops: got %0d expected 1", pops - pb); end
    checks++; if (rx_n - rb !== 4) begin errors++; $display("FAIL single_count: got %0d expected 4", rx_n - rb); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rx_bytes[rb + k] !== exp[k]) begin
        errors++; $display("FAIL single_byte%0d: got %h expected %h", k, rx_bytes[rb + k], exp[k]);
      end
    end
    for (int k = 1; k < 4; k++) begin
      checks++;
      if (starts[sb + k] - starts[sb + k - 1] !== 40) begin
        errors++; $display("FAIL single_frame%0d: got %0d cycles expected 40", k, starts[sb + k] - starts[sb + k - 1]);
      end
    end
    checks++; if (starts[sb] - last_pop_cyc !== 2) begin errors++; $display("FAIL start_latency: got %0d expected 2", starts[sb] - last_pop_cyc); end
    checks++; if (last_busy_cyc - last_pop_cyc + 1 !== 162) begin errors++; $display("FAIL busy_span: got %0d expected 162", last_busy_cyc - last_pop_cyc + 1); end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL single_empty: got %b expected 1", fifo_empty); end
    checks++; if (frame_err - fe !== 0) begin errors++; $display("FAIL single_stop: got %0d bad stop bits expected 0", frame_err - fe); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [12];
    int rb, sb, pb, gap;
    bit ok;
    exp = '{8'h05, 8'h00, 8'h00, 8'h00, 8'h06, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00};
    rb = rx_n; sb = st_n; pb = pops;
    push_word(32'd5);
    push_word(32'd6);
    push_word(32'd7);
    end_push();
    wait_quiet(900, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_done: got busy expected idle within 900 cycles"); end
    checks++; if (pops - pb !== 3) begin errors++; $display("FAIL b2b_pops: got %0d expected 3", pops - pb); end
    checks++; if (rx_n - rb !== 12) begin errors++; $display("FAIL b2b_count: got %0d expected 12", rx_n - rb); end
    for (int k = 0; k < 12; k++) begin
      checks++;
      if (rx_bytes[rb + k] !== exp[k]) begin
        errors++; $display("FAIL b2b_byte%0d: got %h expected %h", k, rx_bytes[rb + k], exp[k]);
      end
    end
    for (int k = 1; k < 12; k++) begin
      gap = ((k % 4) == 0) ? 42 : 40;
      checks++;
      if (starts[sb + k] - starts[sb + k - 1] !== gap) begin
        errors++; $display("FAIL b2b_spacing%0d: got %0d expected %0d", k, starts[sb + k] - starts[sb + k - 1], gap);
      end
    end
  endtask

  task automatic test_full_drain();
    logic [DW-1:0] w;
    logic [7:0]    e;
    int rb, pb;
    bit ok;
    rb = rx_n; pb = pops;
    for (int i = 0; i < 8; i++) push_word(32'h0A0B0C0D + i);
    end_push();
    wait_quiet(1600, ok);
    checks++; if (!ok) begin errors++; $display("FAIL drain_done: got busy expected idle within 1600 cycles"); end
    checks++; if (pops - pb !== 8) begin errors++; $display("FAIL drain_pops: got %0d expected 8", pops - pb); end
    checks++; if (rx_n - rb !== 32) begin errors++; $display("FAIL drain_count: got %0d expected 32", rx_n - rb); end
    for (int k = 0; k < 32; k++) begin
      w = 32'h0A0B0C0D + (k / 4);
      e = w[8 * (k % 4) +: 8];
      checks++;
      if (rx_bytes[rb + k] !== e) begin
        errors++; $display("FAIL drain_byte%0d: got %h expected %h", k, rx_bytes[rb + k], e);
      end
    end
    checks++; if (pop_empty_viol !== 0) begin errors++; $display("FAIL pop_when_empty: got %0d expected 0", pop_empty_viol); end
    checks++; if (pop_busy_viol !== 0) begin errors++; $display("FAIL pop_when_busy: got %0d expected 0", pop_busy_viol); end
  endtask

  task automatic test_mid_frame_reset();
    logic [7:0] exp [4];
    int rb, sb, t0, n;
    bit ok;
    exp = '{8'h78, 8'h56, 8'h34, 8'h12};
    rb = rx_n; sb = st_n; n = 0;
    push_word(32'hFFFF00A5);
    end_push();
    while (st_n == sb && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (st_n == sb) begin
      errors++; $display("FAIL reset_frame_start: got no start bit expected one within 100 cycles");
    end else begin
      t0 = starts[sb];
      while (cyc < t0 + 57 && n < 300) begin @(negedge clk); n++; end
      checks++; if (tx !== 1'b0) begin errors++; $display("FAIL reset_bit3: got %b expected 0", tx); end
      rst = 1'b1;
      #1;
      checks++; if (tx !== 1'b1) begin errors++; $display("FAIL abort_tx: got %b expected 1", tx); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      checks++; if (rx_n - rb !== 1) begin errors++; $display("FAIL abort_partial: got %0d bytes expected 1", rx_n - rb); end
      checks++; if (rx_bytes[rb] !== 8'hA5) begin errors++; $display("FAIL abort_byte0: got %h expected a5", rx_bytes[rb]); end
    end
    rst = 1'b0;
    rb = rx_n;
    push_word(32'h12345678);
    end_push();
    wait_quiet(600, ok);
    checks++; if (!ok) begin errors++; $display("FAIL post_reset_done: got busy expected idle within 600 cycles"); end
    checks++; if (rx_n - rb !== 4) begin errors++; $display("FAIL post_reset_count: got %0d expected 4", rx_n - rb); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rx_bytes[rb + k] !== exp[k]) begin
        errors++; $display("FAIL post_reset_byte%0d: got %h expected %h", k, rx_bytes[rb + k], exp[k]);
      end
    end
  endtask

  task automatic test_invalid_data();
    logic [7:0] exp [4];
    int rb, sb, pb;
    bit ok;
    exp = '{8'hFE, 8'hCA, 8'h00, 8'h00};
    rb = rx_n; sb = st_n; pb = pops;
    kill_req = kill_req + 1;
    push_word(32'hDEADBEEF);
    push_word(32'h0000CAFE);
    end_push();
    wait_quiet(600, ok);
    checks++; if (!ok) begin errors++; $display("FAIL invalid_done: got busy expected idle within 600 cycles"); end
    checks++; if (pops - pb !== 2) begin errors++; $display("FAIL invalid_pops: got %0d expected 2", pops - pb); end
    checks++; if (last_pop_cyc - prev_pop_cyc !== 2) begin errors++; $display("FAIL repop_gap: got %0d expected 2", last_pop_cyc - prev_pop_cyc); end
    checks++; if (starts[sb] - last_pop_cyc !== 2) begin errors++; $display("FAIL invalid_no_start: got %0d expected 2", starts[sb] - last_pop_cyc); end
    checks++; if (rx_n - rb !== 4) begin errors++; $display("FAIL invalid_count: got %0d expected 4", rx_n - rb); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rx_bytes[rb + k] !== exp[k]) begin
        errors++; $display("FAIL invalid_byte%0d: got %h expected %h", k, rx_bytes[rb + k], exp[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_full_drain();
    test_mid_frame_reset();
    test_invalid_data();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500000 time units");
    $fatal(1);
  end

endmodule
